// File: rtl/ysyx_23060124_mem_stage.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_mem_stage
//
// Memory-access stage of the multi-cycle core. One transaction at a time is
// taken from the execute unit. Non-memory instructions pass their ALU result
// through. Each load or store becomes exactly one request/response exchange
// on the data bus, and the result is handed to write-back.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       upstream handshake (o_ready only in IDLE)
//   i_alu_res, i_src2       effective address / store data
//   i_ren, i_wen, i_funct3  load / store / RISC-V size code
//   i_rd                    destination register
//   o_valid / i_ready       write-back handshake
//   o_wb_data, o_rd,
//   o_rd_wen, o_exc         result: data, rd, write enable, exception code
//   o_mem_req_*, o_mem_*    bus request channel (word address, strobes)
//   i_mem_resp_valid,
//   o_mem_resp_ready,
//   i_mem_rdata, i_mem_err  bus response channel
// ---------------------------------------------------------------------------
module ysyx_23060124_mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_ren,
  input  logic            i_wen,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_wb_data,
  output logic [4:0]      o_rd,
  output logic            o_rd_wen,
  output logic [1:0]      o_exc,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_wstrb,
  input  logic            i_mem_resp_valid,
  output logic            o_mem_resp_ready,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_BUS   = 2'b10;
  localparam logic [1:0] EXC_TMO   = 2'b11;

  // Size codes use funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] sh);
    case (size)
      2'b00:   store_strb = 4'b0001 << sh;
      2'b01:   store_strb = 4'b0011 << sh;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate the operand across the word so the strobes alone
  // select the lane; no data shifter is needed.
  function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] src);
    case (size)
      2'b00:   store_data = {4{src[7:0]}};
      2'b01:   store_data = {2{src[15:0]}};
      default: store_data = src;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_data(input logic [2:0] f3, input logic [1:0] sh,
                                                input logic [XLEN-1:0] word);
    logic [XLEN-1:0]        r;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] sx;
    r  = word >> {sh, 3'b000};
    b  = r[7:0];
    h  = r[15:0];
    sx = '0;
    case (f3[1:0])
      2'b00: begin
        sx = XLEN'(b);
        load_data = f3[2] ? XLEN'(r[7:0]) : sx;
      end
      2'b01: begin
        sx = XLEN'(h);
        load_data = f3[2] ? XLEN'(r[15:0]) : sx;
      end
      default: load_data = r;
    endcase
  endfunction

  state_t state, state_nxt;
  logic [7:0] wait_cnt;

  logic accept, mem_op, is_store, misal, timeout_hit;

  assign accept      = i_valid && (state == IDLE);
  assign mem_op      = i_ren || i_wen;
  assign is_store    = i_wen && !i_ren;
  assign misal       = misaligned(i_funct3[1:0], i_alu_res[1:0]);
  assign timeout_hit = (wait_cnt == TO_LAST);

  // Request registers (_p1) hold the accepted transaction.
  logic [XLEN-1:0] addr_p1, wdata_p1;
  logic [3:0]      wstrb_p1;
  logic            wen_p1;
  logic [2:0]      funct3_p1;
  logic [4:0]      rd_p1;

  // Result registers (_p2) drive the write-back outputs.
  logic [XLEN-1:0] wb_data_p2;
  logic [4:0]      rd_p2;
  logic            rd_wen_p2;
  logic [1:0]      exc_p2;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (!mem_op || misal) ? DONE : REQ;
      REQ:  if (i_mem_req_ready) state_nxt = WAIT;
      WAIT: if (i_mem_resp_valid || timeout_hit) state_nxt = DONE;
      DONE: if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held at zero while requesting, so it starts from zero after the handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                                 wait_cnt <= 8'd0;
    else if (state == REQ)                                     wait_cnt <= 8'd0;
    else if (state == WAIT && !i_mem_resp_valid && !timeout_hit) wait_cnt <= wait_cnt + 8'd1;
  end

  // ---- accept -> request stage boundary ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_p1   <= i_alu_res;
      wen_p1    <= is_store;
      wstrb_p1  <= is_store ? store_strb(i_funct3[1:0], i_alu_res[1:0]) : 4'b0000;
      wdata_p1  <= is_store ? store_data(i_funct3[1:0], i_src2) : '0;
      funct3_p1 <= i_funct3;
      rd_p1     <= i_rd;
    end
  end

  // ---- response -> write-back stage boundary ----
  // Result registers are reset so the outputs read zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_data_p2 <= '0;
      rd_p2      <= 5'd0;
      rd_wen_p2  <= 1'b0;
      exc_p2     <= EXC_NONE;
    end else if (accept) begin
      rd_p2      <= i_rd;
      wb_data_p2 <= mem_op ? '0 : i_alu_res;
      rd_wen_p2  <= !mem_op && (i_rd != 5'd0);
      exc_p2     <= (mem_op && misal) ? EXC_MISAL : EXC_NONE;
    end else if (state == WAIT) begin
      if (i_mem_resp_valid) begin
        if (i_mem_err) begin
          wb_data_p2 <= '0;
          rd_wen_p2  <= 1'b0;
          exc_p2     <= EXC_BUS;
        end else if (wen_p1) begin
          wb_data_p2 <= '0;
          rd_wen_p2  <= 1'b0;
          exc_p2     <= EXC_NONE;
        end else begin
          wb_data_p2 <= load_data(funct3_p1, addr_p1[1:0], i_mem_rdata);
          rd_wen_p2  <= (rd_p1 != 5'd0);
          exc_p2     <= EXC_NONE;
        end
      end else if (timeout_hit) begin
        wb_data_p2 <= '0;
        rd_wen_p2  <= 1'b0;
        exc_p2     <= EXC_TMO;
      end
    end
  end

  always_comb begin
    o_ready          = (state == IDLE);
    o_valid          = (state == DONE);
    o_mem_req_valid  = (state == REQ);
    o_mem_resp_ready = (state == WAIT);
    o_mem_addr       = '0;
    o_mem_wen        = 1'b0;
    o_mem_wdata      = '0;
    o_mem_wstrb      = 4'b0000;
    if (state == REQ) begin
      o_mem_addr  = {addr_p1[XLEN-1:2], 2'b00};
      o_mem_wen   = wen_p1;
      o_mem_wdata = wdata_p1;
      o_mem_wstrb = wstrb_p1;
    end
  end

  assign o_wb_data = wb_data_p2;
  assign o_rd      = rd_p2;
  assign o_rd_wen  = rd_wen_p2;
  assign o_exc     = exc_p2;

endmodule

// File: tb/tb_ysyx_23060124_mem_stage.sv
module tb_ysyx_23060124_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, valid, ready_up, ren, wen, wb_ready;
  logic [31:0] alu_res, src2;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        out_valid, rd_wen;
  logic [31:0] wb_data;
  logic [4:0]  out_rd;
  logic [1:0]  exc;
  logic        req_valid, req_ready, mem_wen, resp_valid, resp_ready, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  ysyx_23060124_mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_up),
    .i_alu_res(alu_res), .i_src2(src2), .i_ren(ren), .i_wen(wen),
    .i_funct3(funct3), .i_rd(rd), .o_valid(out_valid), .i_ready(wb_ready),
    .o_wb_data(wb_data), .o_rd(out_rd), .o_rd_wen(rd_wen), .o_exc(exc),
    .o_mem_req_valid(req_valid), .i_mem_req_ready(req_ready),
    .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_resp_valid(resp_valid),
    .o_mem_resp_ready(resp_ready), .i_mem_rdata(mem_rdata), .i_mem_err(mem_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [1:0]  exc;
  } res_t;

  res_t exp_q[$];

  // rs: cycles req_ready is held low; rdl: WAIT cycles before the response;
  // respond=0 means no response at all (timeout expected).
  typedef struct {
    string       name;
    logic        ren, wen;
    logic [2:0]  f3;
    logic [31:0] alu, src2;
    logic [4:0]  rd;
    int          rs, rdl;
    bit          respond;
    logic [31:0] rdata;
    logic        err;
    logic        bus;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic [31:0] data;
    logic        rd_wen;
    logic [1:0]  exc;
  } vec_t;

  vec_t vecs[$];

  task automatic run(input vec_t v);
    int   cyc, waited, rs_left, lat;
    bit   seen_bus, done;
    res_t e;
    for (int k = 0; k < 10 && !ready_up; k++) @(negedge clk);
    chk({v.name, "_accept_ready"}, 32'(ready_up), 32'd1);
    alu_res = v.alu; src2 = v.src2; ren = v.ren; wen = v.wen;
    funct3 = v.f3; rd = v.rd; valid = 1'b1;
    e.data = v.data; e.rd = v.rd; e.rd_wen = v.rd_wen; e.exc = v.exc;
    exp_q.push_back(e);
    if (!v.bus)          lat = 1;
    else if (v.respond)  lat = 3 + v.rs + v.rdl;
    else                 lat = 2 + v.rs + TO;
    cyc = 0; waited = 0; seen_bus = 1'b0; done = 1'b0; rs_left = v.rs;
    while (!done && cyc < TO + 40) begin
      @(negedge clk);
      cyc++;
      valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; mem_err = 1'b0;
      mem_rdata = 32'h0; wb_ready = 1'b0;
      if (req_valid) begin
        seen_bus = 1'b1;
        chk({v.name, "_addr"},  mem_addr,  {v.alu[31:2], 2'b00});
        chk({v.name, "_mwen"},  32'(mem_wen), 32'(v.wen && !v.ren));
        chk({v.name, "_wdata"}, mem_wdata, v.mwdata);
        chk({v.name, "_wstrb"}, 32'(mem_wstrb), 32'(v.mwstrb));
        if (rs_left == 0) req_ready = 1'b1;
        else rs_left--;
      end
      if (resp_ready) begin
        if (v.respond && waited >= v.rdl) begin
          resp_valid = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
        end
        waited++;
      end
      if (out_valid) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          chk({v.name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk({v.name, "_wb_data"}, wb_data, e.data);
          chk({v.name, "_rd"},      32'(out_rd), 32'(e.rd));
          chk({v.name, "_rd_wen"},  32'(rd_wen), 32'(e.rd_wen));
          chk({v.name, "_exc"},     32'(exc), 32'(e.exc));
        end
        chk({v.name, "_latency"}, 32'(cyc), 32'(lat));
        chk({v.name, "_ready_in_done"}, 32'(ready_up), 32'd0);
        wb_ready = 1'b1;
        // A response arriving after a timeout must be ignored.
        if (v.bus && !v.respond) begin
          resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_err = 1'b0;
        end
      end
    end
    if (!done) begin
      chk({v.name, "_o_valid_seen"}, 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    chk({v.name, "_bus_activity"}, 32'(seen_bus), 32'(v.bus));
    @(negedge clk);
    wb_ready = 1'b0;
    chk({v.name, "_valid_dropped"}, 32'(out_valid), 32'd0);
    chk({v.name, "_ready_back"}, 32'(ready_up), 32'd1);
    chk({v.name, "_resp_ready_idle"}, 32'(resp_ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; ren = 1'b0; wen = 1'b0; funct3 = 3'b000; rd = 5'd0;
    alu_res = 32'h0; src2 = 32'h0; wb_ready = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;

    //          name        ren   wen   f3      alu            src2           rd   rs rdl resp  rdata          err   bus   mwdata         mwstrb   data           rd_wen exc
    vecs.push_back('{"alu_pass", 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,         5'd5,  0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h1234_5678, 1'b1, 2'b00});
    vecs.push_back('{"lb",       1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,         5'd7,  0, 0, 1'b1, 32'h80FF_0011, 1'b0, 1'b1, 32'h0,         4'b0000, 32'hFFFF_FF80, 1'b1, 2'b00});
    vecs.push_back('{"lbu",      1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,         5'd7,  0, 0, 1'b1, 32'h80FF_0011, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0000_0080, 1'b1, 2'b00});
    vecs.push_back('{"lhu",      1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0,         5'd7,  0, 0, 1'b1, 32'h80FF_0011, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0000_80FF, 1'b1, 2'b00});
    vecs.push_back('{"sh",       1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 5'd9,  0, 0, 1'b1, 32'h0,         1'b0, 1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0,         1'b0, 2'b00});
    vecs.push_back('{"lw_misal", 1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0,         5'd10, 0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 2'b01});
    vecs.push_back('{"lh_neg",   1'b1, 1'b0, 3'b001, 32'h0000_1000, 32'h0,         5'd3,  0, 1, 1'b1, 32'h1234_8001, 1'b0, 1'b1, 32'h0,         4'b0000, 32'hFFFF_8001, 1'b1, 2'b00});
    vecs.push_back('{"lw_rd0",   1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         5'd0,  1, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 2'b00});
    vecs.push_back('{"sb",       1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 5'd11, 0, 0, 1'b1, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, 4'b0010, 32'h0,         1'b0, 2'b00});
    vecs.push_back('{"sw",       1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 5'd12, 0, 0, 1'b1, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0,         1'b0, 2'b00});
    vecs.push_back('{"alu_rd0",  1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, 32'h0,         5'd0,  0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0, 2'b00});
    vecs.push_back('{"ren_wen",  1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h9999_9999, 5'd6,  0, 0, 1'b1, 32'h55AA_55AA, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h55AA_55AA, 1'b1, 2'b00});
    vecs.push_back('{"lh_misal", 1'b1, 1'b0, 3'b001, 32'h0000_0041, 32'h0,         5'd6,  0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 2'b01});
    vecs.push_back('{"lhu_stall",1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,         5'd13, 2, 2, 1'b1, 32'h1111_F00F, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0000_F00F, 1'b1, 2'b00});
    vecs.push_back('{"lw_err",   1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,         5'd8,  3, 0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         4'b0000, 32'h0,         1'b0, 2'b10});
    vecs.push_back('{"lw_tmo",   1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         5'd8,  0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         1'b0, 2'b11});
    vecs.push_back('{"lb_after", 1'b1, 1'b0, 3'b000, 32'h0000_0301, 32'h0,         5'd8,  0, 0, 1'b1, 32'h0000_7F00, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0000_007F, 1'b1, 2'b00});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",      32'(ready_up),   32'd1);
    chk("rst_valid",      32'(out_valid),  32'd0);
    chk("rst_wb_data",    wb_data,         32'h0);
    chk("rst_rd_wen",     32'(rd_wen),     32'd0);
    chk("rst_exc",        32'(exc),        32'd0);
    chk("rst_req_valid",  32'(req_valid),  32'd0);
    chk("rst_wstrb",      32'(mem_wstrb),  32'd0);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);

    foreach (vecs[i]) run(vecs[i]);

    // Reset while waiting for a response drops the transaction.
    for (int k = 0; k < 10 && !ready_up; k++) @(negedge clk);
    alu_res = 32'h0000_0400; ren = 1'b1; wen = 1'b0; funct3 = 3'b010; rd = 5'd4; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("mrst_in_req", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("mrst_in_wait", 32'(resp_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid",      32'(out_valid),  32'd0);
    chk("mrst_ready",      32'(ready_up),   32'd1);
    chk("mrst_req_valid",  32'(req_valid),  32'd0);
    chk("mrst_resp_ready", 32'(resp_ready), 32'd0);
    chk("mrst_wb_data",    wb_data,         32'h0);

    run('{"lw_post_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 5'd4, 0, 0, 1'b1,
          32'h0F0E_0D0C, 1'b0, 1'b1, 32'h0, 4'b0000, 32'h0F0E_0D0C, 1'b1, 2'b00});

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_mem_stage.md
# ysyx_23060124_mem_stage

Memory-access stage of the multi-cycle core, between the execute unit (ALU result, store data, load/store opcode) and the write-back unit. It converts one load or store per transaction into a single request/response exchange on the data-memory bus. It applies byte-lane strobes for stores and shift/sign-extension for loads. Non-memory instructions pass their ALU result through with fixed one-cycle latency.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- TIMEOUT, 255: maximum cycles in WAIT before the transaction is aborted with an error (1..255).

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream transaction valid.
- o_ready  out  1  stage can accept; high only in IDLE.
- i_alu_res  in  32  ALU result; the effective address for loads/stores.
- i_src2  in  32  store data.
- i_ren / i_wen  in  1 / 1  load / store; both high is illegal and treated as load.
- i_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU only meaningful for loads).
- i_rd  in  5  destination register.
- o_valid  out  1  result valid to write-back.
- i_ready  in  1  write-back accepts.
- o_wb_data  out  32  load data or passed ALU result; 0 for stores.
- o_rd  out  5  destination register.
- o_rd_wen  out  1  register write enable; 0 for stores, errors and rd==0.
- o_exc  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
- o_mem_req_valid  out  1  bus request valid.
- i_mem_req_ready  in  1  bus request accepted.
- o_mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- o_mem_wen  out  1  1 = write request.
- o_mem_wdata  out  32  lane-shifted store data.
- o_mem_wstrb  out  4  byte strobes; 0000 on reads.
- i_mem_resp_valid  in  1  response valid.
- o_mem_resp_ready  out  1  high only in WAIT.
- i_mem_rdata  in  32  read data (full word).
- i_mem_err  in  1  response carries error.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset sets IDLE; all outputs 0 except o_ready=1.
- IDLE: on i_valid&&o_ready, latch all inputs.
  - If neither i_ren nor i_wen: o_wb_data=i_alu_res, o_rd_wen=(rd!=0), go to DONE.
  - If the access is misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no bus request, o_exc=01, go to DONE.
  - Otherwise go to REQ.
- REQ: o_mem_req_valid=1; address, wen, wdata and wstrb stay stable until i_mem_req_ready. On handshake go to WAIT and clear the timeout counter.
- Store lanes, with sh=addr[1:0]:
  - B: wstrb=0001<<sh, wdata=src2[7:0] replicated to all four bytes.
  - H: wstrb=0011<<sh, wdata={2{src2[15:0]}}.
  - W: wstrb=1111, wdata=src2.
- WAIT: o_mem_resp_ready=1; the counter increments each cycle.
  - On i_mem_resp_valid: if i_mem_err, o_exc=10 and o_rd_wen=0; otherwise compute load data. Go to DONE.
  - If the counter reaches TIMEOUT with no response: o_exc=11, o_rd_wen=0, go to DONE. A late response is ignored, because o_mem_resp_ready=0 outside WAIT.
- Load data: r = i_mem_rdata >> (8*sh). B sign-extends r[7:0], H sign-extends r[15:0], W takes r, BU/HU zero-extend.
- DONE: o_valid=1, all result outputs held stable. On i_ready go to IDLE; o_ready rises the following cycle (no same-cycle re-accept).
- Reset in any state returns to IDLE at the next edge and clears o_valid and o_mem_req_valid; the in-flight transaction is dropped. The memory slave shares i_rst.

## Timing
- Non-memory op: accepted at cycle N, o_valid at N+1.
- Load or store with req_ready=1 and response one cycle after the handshake: accept N, request N+1, response N+2, o_valid N+3.
- Each cycle of req_ready or resp_valid stall adds exactly one cycle.
- Misaligned access: o_valid at N+1, with zero bus activity.
- Throughput: at most one transaction per 2 cycles (DONE→IDLE→accept).

## Test plan
- ALU pass-through: alu_res=0x1234_5678, rd=5 → o_valid at N+1, wb_data=0x12345678, rd_wen=1; no bus request.
- LB at 0x8000_0003 with rdata=0x80FF_0011 → wb_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x8000_0002 → 0x0000_80FF.
- SH at 0x8000_0002 with src2=0xAAAA_BEEF → wstrb=1100, wdata=0xBEEF_BEEF, wb_data=0, rd_wen=0.
- LW at 0x8000_0006 → o_exc=01 at N+1; o_mem_req_valid never asserted.
- req_ready held low 3 cycles, then the response returns with err=1 → request stable throughout, o_exc=10, rd_wen=0. No response for TIMEOUT cycles → o_exc=11, and a response arriving afterwards is ignored.
- i_rst asserted during WAIT, then a new LW issued → IDLE next cycle, o_valid=0; the new LW completes normally with correct data.
